mmu_tlb: RTL and testbench

//  Fully-associative Sv32 translation lookaside buffer; responder side of the MMU walker's
//  tlb_read/tlb_write interface. Serves VPN->PPN+flag lookups with a registered 1-cycle

---
 rtl/mmu_tlb_if.sv | 37 +++
 rtl/mmu_tlb.sv | 176 +++++++++++++++++
 tb/tb_mmu_tlb.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_tlb_if.sv
// Requester/responder bundle for the Sv32 TLB.
// The walker/MMU side drives requests and the TLB answers.
interface mmu_tlb_if #(
  parameter int VPN_W  = 20,
  parameter int PPN_W  = 20,
  parameter int FLAG_W = 8
) ();
  logic              tlb_read;
  logic              tlb_write;
  logic              flush_tlb;
  logic [VPN_W-1:0]  vpn;
  logic [PPN_W-1:0]  wr_ppn;
  logic [FLAG_W-1:0] wr_flags;
  logic              tlb_resp;
  logic              tlb_hit;
  logic [PPN_W-1:0]  ppn_out;
  logic [FLAG_W-1:0] flags_out;
  logic              busy;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport master (
    output tlb_read, tlb_write, flush_tlb,
    output vpn, wr_ppn, wr_flags,
    input  tlb_resp, tlb_hit, ppn_out,
    input  flags_out, busy,
    input  hit_count, miss_count
  );

  modport slave (
    input  tlb_read, tlb_write, flush_tlb,
    input  vpn, wr_ppn, wr_flags,
    output tlb_resp, tlb_hit, ppn_out,
    output flags_out, busy,
    output hit_count, miss_count
  );
endinterface

// File: rtl/mmu_tlb.sv
// Fully-associative Sv32 TLB: registered lookups,
// in-place/fill/round-robin installs, sequential flush.
module mmu_tlb #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20,
  parameter int FLAG_W  = 8
) (
  input logic     clk,
  input logic     rst,
  mmu_tlb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    FLUSH
  } state_t;

  typedef struct packed {
    logic              v;
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ppn;
    logic [FLAG_W-1:0] flags;
  } ent_t;

  state_t            state_q, state_d;
  ent_t              tab_q [ENTRIES];
  ent_t              tab_d [ENTRIES];
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hit_q, hit_d;
  logic [PPN_W-1:0]  ppn_q, ppn_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [31:0]       hc_q, hc_d;
  logic [31:0]       mc_q, mc_d;

  logic              lk_hit;
  logic [PPN_W-1:0]  lk_ppn;
  logic [FLAG_W-1:0] lk_flags;
  logic              m_found;
  logic [IDX_W-1:0]  m_idx;
  logic              f_found;
  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              evict;
  logic              do_wr;

  always_comb begin
    lk_hit   = 1'b0;
    lk_ppn   = '0;
    lk_flags = '0;
    m_found  = 1'b0;
    m_idx    = '0;
    f_found  = 1'b0;
    f_idx    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (tab_q[i].v && tab_q[i].vpn == bus.vpn
          && !m_found) begin
        m_found  = 1'b1;
        m_idx    = IDX_W'(i);
        lk_hit   = 1'b1;
        lk_ppn   = tab_q[i].ppn;
        lk_flags = tab_q[i].flags;
      end
      if (!tab_q[i].v && !f_found) begin
        f_found = 1'b1;
        f_idx   = IDX_W'(i);
      end
    end
  end

  // Installs reuse a matching slot, then the lowest free one,
  // and only fall back to round-robin eviction when full.
  always_comb begin
    evict  = !m_found && !f_found;
    wr_idx = m_found ? m_idx :
             f_found ? f_idx : ptr_q;
    do_wr  = bus.tlb_write && !bus.flush_tlb
             && state_q != FLUSH;
  end

  always_comb begin
    state_d = state_q;
    tab_d   = tab_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    ppn_d   = ppn_q;
    flags_d = flags_q;
    hc_d    = hc_q;
    mc_d    = mc_q;

    if (state_q == RESP) begin
      if (hit_q && hc_q != '1)
        hc_d = hc_q + 32'd1;
      if (!hit_q && mc_q != '1)
        mc_d = mc_q + 32'd1;
    end

    if (do_wr) begin
      tab_d[wr_idx] = '{v: 1'b1,
                        vpn: bus.vpn,
                        ppn: bus.wr_ppn,
                        flags: bus.wr_flags};
      if (evict)
        ptr_d = ptr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.tlb_read && !bus.tlb_write) begin
          hit_d   = lk_hit;
          ppn_d   = lk_ppn;
          flags_d = lk_flags;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      FLUSH: begin
        tab_d[idx_q].v = 1'b0;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush_tlb) begin
      state_d = FLUSH;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < ENTRIES; i++)
        tab_q[i] <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      ppn_q   <= '0;
      flags_q <= '0;
      hc_q    <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < ENTRIES; i++)
        tab_q[i] <= tab_d[i];
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      ppn_q   <= ppn_d;
      flags_q <= flags_d;
      hc_q    <= hc_d;
      mc_q    <= mc_d;
    end
  end

  always_comb begin
    bus.tlb_resp   = state_q == RESP;
    bus.tlb_hit    = bus.tlb_resp && hit_q;
    bus.ppn_out    = bus.tlb_hit ? ppn_q : '0;
    bus.flags_out  = bus.tlb_hit ? flags_q : '0;
    bus.busy       = state_q == FLUSH;
    bus.hit_count  = hc_q;
    bus.miss_count = mc_q;
  end
endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb against a
// slot-table reference model of the install/flush rules.
module tb_mmu_tlb;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mmu_tlb_if bus ();

  mmu_tlb #(
    .ENTRIES(8), .VPN_W(20),
    .PPN_W(20), .FLAG_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          m_v   [8];
  logic [19:0] m_vpn [8];
  logic [19:0] m_ppn [8];
  logic [7:0]  m_fl  [8];
  int          m_ptr;
  int          m_hits;
  int          m_miss;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_v[i] = 0;
    m_ptr  = 0;
    m_hits = 0;
    m_miss = 0;
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < 8; i++) m_v[i] = 0;
    m_ptr = 0;
  endfunction

  function automatic void m_write(
    input logic [19:0] v, input logic [19:0] p,
    input logic [7:0] f);
    int slot;
    slot = -1;
    for (int i = 0; i < 8; i++)
      if (slot < 0 && m_v[i] && m_vpn[i] == v) slot = i;
    if (slot < 0)
      for (int i = 0; i < 8; i++)
        if (slot < 0 && !m_v[i]) slot = i;
    if (slot < 0) begin
      slot  = m_ptr;
      m_ptr = (m_ptr + 1) % 8;
    end
    m_v[slot]   = 1;
    m_vpn[slot] = v;
    m_ppn[slot] = p;
    m_fl[slot]  = f;
  endfunction

  function automatic void m_lookup(
    input logic [19:0] v, output logic h,
    output logic [19:0] p, output logic [7:0] f);
    h = 0; p = '0; f = '0;
    for (int i = 0; i < 8; i++)
      if (m_v[i] && m_vpn[i] == v) begin
        h = 1; p = m_ppn[i]; f = m_fl[i];
      end
  endfunction

  task automatic idle_inputs();
    bus.tlb_read  = 0;
    bus.tlb_write = 0;
    bus.flush_tlb = 0;
    bus.vpn       = '0;
    bus.wr_ppn    = '0;
    bus.wr_flags  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    m_reset();
  endtask

  task automatic do_write(
    input logic [19:0] v, input logic [19:0] p,
    input logic [7:0] f);
    bus.tlb_write = 1;
    bus.vpn       = v;
    bus.wr_ppn    = p;
    bus.wr_flags  = f;
    @(negedge clk);
    bus.tlb_write = 0;
    m_write(v, p, f);
  endtask

  task automatic lookup(
    input logic [19:0] v, output bit got,
    output int lat, output logic h,
    output logic [19:0] p, output logic [7:0] f);
    bus.tlb_read = 1;
    bus.vpn      = v;
    got = 0; lat = 0; h = 0; p = '0; f = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (bus.tlb_resp) begin
        got = 1;
        h = bus.tlb_hit;
        p = bus.ppn_out;
        f = bus.flags_out;
        break;
      end
    end
    bus.tlb_read = 0;
    @(negedge clk);
  endtask

  // Looks up v and compares against the model.
  task automatic check_lookup(input logic [19:0] v,
                              input string tag);
    bit got; int lat;
    logic h, eh;
    logic [19:0] p, ep;
    logic [7:0] f, ef;
    lookup(v, got, lat, h, p, f);
    m_lookup(v, eh, ep, ef);
    if (eh) m_hits++; else m_miss++;
    checks++;
    if (!got || h !== eh || p !== ep || f !== ef) begin
      failures++;
      $display("FAIL %s vpn=%h got=%0b hit=%b ppn=%h fl=%h exp hit=%b ppn=%h fl=%h",
               tag, v, got, h, p, f, eh, ep, ef);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.tlb_resp !== 0 || bus.tlb_hit !== 0 ||
        bus.ppn_out !== 0 || bus.flags_out !== 0 ||
        bus.busy !== 0) begin
      failures++;
      $display("FAIL reset_outs resp=%b hit=%b ppn=%h fl=%h busy=%b exp all 0",
               bus.tlb_resp, bus.tlb_hit, bus.ppn_out,
               bus.flags_out, bus.busy);
    end
    checks++;
    if (bus.hit_count !== 0 || bus.miss_count !== 0) begin
      failures++;
      $display("FAIL reset_cnt hc=%0d mc=%0d exp 0 0",
               bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_first_miss();
    bit got; int lat; logic h;
    logic [19:0] p; logic [7:0] f;
    lookup(20'h12345, got, lat, h, p, f);
    m_miss++;
    checks++;
    if (!got || lat != 1 || h !== 0 || p !== 0) begin
      failures++;
      $display("FAIL first_miss got=%0b lat=%0d hit=%b ppn=%h exp 1 1 0 0",
               got, lat, h, p);
    end
    checks++;
    if (bus.miss_count !== 32'd1) begin
      failures++;
      $display("FAIL first_miss_cnt mc=%0d exp 1", bus.miss_count);
    end
  endtask

  task automatic test_hit();
    bit got; int lat; logic h;
    logic [19:0] p; logic [7:0] f;
    do_write(20'h12345, 20'hABCDE, 8'hCF);
    lookup(20'h12345, got, lat, h, p, f);
    m_hits++;
    checks++;
    if (!got || lat != 1 || h !== 1 ||
        p !== 20'hABCDE || f !== 8'hCF) begin
      failures++;
      $display("FAIL hit got=%0b lat=%0d hit=%b ppn=%h fl=%h exp 1 1 1 abcde cf",
               got, lat, h, p, f);
    end
    checks++;
    if (bus.hit_count !== 32'd1) begin
      failures++;
      $display("FAIL hit_cnt hc=%0d exp 1", bus.hit_count);
    end
  endtask

  task automatic test_evict();
    do_reset();
    for (int i = 0; i < 9; i++)
      do_write(20'h100 + 20'(i), 20'h500 + 20'(i), 8'(i + 1));
    check_lookup(20'h100, "evict_oldest");
    for (int i = 1; i < 9; i++)
      check_lookup(20'h100 + 20'(i), "evict_keep");
    do_write(20'h105, 20'h1, 8'h3);
    check_lookup(20'h101, "inplace_other");
    check_lookup(20'h105, "inplace_new");
    checks++;
    if (bus.hit_count !== 32'(m_hits) ||
        bus.miss_count !== 32'(m_miss)) begin
      failures++;
      $display("FAIL evict_cnt hc=%0d mc=%0d exp %0d %0d",
               bus.hit_count, bus.miss_count, m_hits, m_miss);
    end
  endtask

  task automatic test_flush();
    int n;
    bit r0;
    bus.flush_tlb = 1;
    @(negedge clk);
    bus.flush_tlb = 0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      if (n == 1) begin
        bus.tlb_read = 1;
        bus.vpn = 20'h101;
      end
      if (n == 3) begin
        bus.tlb_write = 1;
        bus.vpn = 20'h1FF;
        bus.wr_ppn = 20'h42;
        bus.wr_flags = 8'h11;
      end
      if (n == 4) begin
        bus.tlb_write = 0;
        bus.vpn = 20'h101;
      end
      @(negedge clk);
    end
    m_flush();
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL flush_busy cycles=%0d exp 8", n);
    end
    r0 = bus.tlb_resp;
    @(negedge clk);
    checks++;
    if (r0 !== 0 || bus.tlb_resp !== 1 ||
        bus.tlb_hit !== 0) begin
      failures++;
      $display("FAIL flush_held_read resp0=%b resp=%b hit=%b exp 0 1 0",
               r0, bus.tlb_resp, bus.tlb_hit);
    end
    m_miss++;
    bus.tlb_read = 0;
    @(negedge clk);
    check_lookup(20'h1FF, "flush_drop_wr");
    check_lookup(20'h102, "flush_cleared");
  endtask

  task automatic test_rw_same();
    logic r0;
    bus.tlb_read  = 1;
    bus.tlb_write = 1;
    bus.vpn       = 20'h2A;
    bus.wr_ppn    = 20'h77;
    bus.wr_flags  = 8'h0F;
    @(negedge clk);
    r0 = bus.tlb_resp;
    bus.tlb_write = 0;
    m_write(20'h2A, 20'h77, 8'h0F);
    @(negedge clk);
    checks++;
    if (r0 !== 0 || bus.tlb_resp !== 1 ||
        bus.tlb_hit !== 1 || bus.ppn_out !== 20'h77) begin
      failures++;
      $display("FAIL rw_same resp0=%b resp=%b hit=%b ppn=%h exp 0 1 1 77",
               r0, bus.tlb_resp, bus.tlb_hit, bus.ppn_out);
    end
    m_hits++;
    bus.tlb_read = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [19:0] v;
    for (int k = 0; k < 80; k++) begin
      v = 20'h300 + 20'($urandom_range(0, 11));
      if ($urandom_range(0, 2) == 0)
        do_write(v, 20'($urandom), 8'($urandom));
      else
        check_lookup(v, "random");
    end
    checks++;
    if (bus.hit_count !== 32'(m_hits) ||
        bus.miss_count !== 32'(m_miss)) begin
      failures++;
      $display("FAIL random_cnt hc=%0d mc=%0d exp %0d %0d",
               bus.hit_count, bus.miss_count, m_hits, m_miss);
    end
  endtask

  task automatic test_reset_mid();
    do_write(20'h2B, 20'h99, 8'h01);
    bus.flush_tlb = 1;
    @(negedge clk);
    bus.flush_tlb = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_reset();
    checks++;
    if (bus.busy !== 0 || bus.tlb_resp !== 0 ||
        bus.hit_count !== 0 || bus.miss_count !== 0) begin
      failures++;
      $display("FAIL rst_in_flush busy=%b resp=%b hc=%0d mc=%0d exp 0",
               bus.busy, bus.tlb_resp,
               bus.hit_count, bus.miss_count);
    end
    do_write(20'h2C, 20'h55, 8'h07);
    bus.tlb_read = 1;
    bus.vpn = 20'h2C;
    @(negedge clk);
    checks++;
    if (bus.tlb_resp !== 1 || bus.tlb_hit !== 1) begin
      failures++;
      $display("FAIL pre_rst_resp resp=%b hit=%b exp 1 1",
               bus.tlb_resp, bus.tlb_hit);
    end
    bus.tlb_read = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_reset();
    checks++;
    if (bus.tlb_resp !== 0 || bus.tlb_hit !== 0 ||
        bus.ppn_out !== 0 || bus.flags_out !== 0 ||
        bus.busy !== 0 || bus.hit_count !== 0 ||
        bus.miss_count !== 0) begin
      failures++;
      $display("FAIL rst_in_resp resp=%b hit=%b ppn=%h fl=%h busy=%b hc=%0d mc=%0d exp 0",
               bus.tlb_resp, bus.tlb_hit, bus.ppn_out,
               bus.flags_out, bus.busy,
               bus.hit_count, bus.miss_count);
    end
    check_lookup(20'h2C, "post_rst_miss");
    check_lookup(20'h2B, "post_rst_miss2");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1;
    idle_inputs();
    m_reset();
    @(negedge clk);
    test_reset();
    test_first_miss();
    test_hit();
    test_evict();
    test_flush();
    test_rw_same();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
